// File: rtl/booth_div_nr.sv
// ---------------------------------------------------------------------------
// booth_div_nr
//
// Purpose:
//   Sequential signed radix-2 non-restoring divider. This is the companion to
//   the radix-4 Booth multiplier in the same arithmetic datapath. It takes a
//   two's-complement dividend and divisor and, after a fixed number of
//   iterations, returns a quotient truncated toward zero and a remainder
//   whose sign follows the dividend. Operand magnitudes are divided unsigned,
//   and the signs are re-applied in a final fix-up cycle.
//
// Parameters:
//   WIDTH       operand / quotient / remainder width, two's complement (2..32)
//
// Ports:
//   clk          in   rising-edge clock
//   resetn       in   asynchronous active-low reset
//   start        in   request, sampled only while busy=0
//   dividend     in   [WIDTH-1:0] signed dividend, captured when start is accepted
//   divisor      in   [WIDTH-1:0] signed divisor, captured when start is accepted
//   busy         out  operation in progress; start is ignored while high
//   valid        out  one-cycle pulse; quotient/remainder/div_by_zero updated
//   quotient     out  [WIDTH-1:0] signed quotient
//   remainder    out  [WIDTH-1:0] signed remainder
//   div_by_zero  out  high together with valid when the divisor was zero
//
// Configuration macro:
//   BOOTH_DIV_DZ_BYPASS_EN  when defined, a zero divisor skips the iteration
//                           phase and completes two edges after start. When
//                           undefined, every operand takes WIDTH+2 edges.
//                           Result values are identical in both builds.
// ---------------------------------------------------------------------------
module booth_div_nr #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ITER,
        FIX
    } state_t;

    state_t             r_state;
    state_t             w_nextState;

    // Captured operand information.
    logic [WIDTH-1:0]   r_dividend;
    logic               r_negQuot;
    logic               r_negRem;
    logic               r_divZero;
    logic [WIDTH:0]     r_dMag;

    // Iteration datapath: P is the signed partial remainder, and Q holds the
    // dividend magnitude (shifted up one place) and then collects quotient
    // bits from the bottom.
    logic [WIDTH+1:0]   r_p;
    logic [WIDTH:0]     r_q;
    logic [CNT_W-1:0]   r_count;

    // Result registers.
    logic               r_valid;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_dbz;

    logic [WIDTH-1:0]   w_dividendMag;
    logic [WIDTH:0]     w_divisorExt;
    logic [WIDTH:0]     w_divisorMag;
    logic [WIDTH+1:0]   w_dExt;
    logic [WIDTH+1:0]   w_pShift;
    logic [WIDTH+1:0]   w_pNext;
    logic [WIDTH:0]     w_qNext;
    logic [WIDTH-1:0]   w_remMag;
    logic [WIDTH-1:0]   w_qSigned;
    logic [WIDTH-1:0]   w_rSigned;

    // Magnitudes of the incoming operands. The dividend magnitude of
    // -2^(WIDTH-1) still fits in WIDTH bits when it is read as unsigned. The
    // divisor is widened by one bit so that its magnitude can be added to the
    // (WIDTH+2)-bit partial remainder without ambiguity.
    always_comb begin
        w_dividendMag = dividend[WIDTH-1] ? (-dividend) : dividend;
        w_divisorExt  = {divisor[WIDTH-1], divisor};
        w_divisorMag  = divisor[WIDTH-1] ? (-w_divisorExt) : w_divisorExt;
    end

    // One non-restoring step: shift {P,Q} left by one, then subtract the
    // divisor magnitude when P was non-negative, otherwise add it back. The
    // new quotient bit is the inverted sign of the updated P. Because the
    // dividend was loaded one place up in Q, bringing in Q's MSB feeds the
    // dividend magnitude bits into P, MSB first, over exactly WIDTH steps.
    always_comb begin
        w_dExt   = {1'b0, r_dMag};
        w_pShift = {r_p[WIDTH:0], r_q[WIDTH]};
        w_pNext  = r_p[WIDTH+1] ? (w_pShift + w_dExt) : (w_pShift - w_dExt);
        w_qNext  = {r_q[WIDTH-1:0], ~w_pNext[WIDTH+1]};
    end

    // Fix-up: restore a negative final remainder, then apply the signs. Only
    // the low WIDTH bits survive, because |remainder| < |divisor| <= 2^(WIDTH-1).
    // The quotient wraps for -2^(WIDTH-1) / -1, as intended.
    always_comb begin
        w_remMag  = r_p[WIDTH+1] ? (r_p[WIDTH-1:0] + r_dMag[WIDTH-1:0])
                                 : r_p[WIDTH-1:0];
        w_qSigned = r_negQuot ? (-r_q[WIDTH-1:0]) : r_q[WIDTH-1:0];
        w_rSigned = r_negRem  ? (-w_remMag)       : w_remMag;
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic and busy. The iteration phase ends after WIDTH steps.
    // In the bypass build, a zero divisor goes straight from LOAD to FIX.
    always_comb begin
        w_nextState = r_state;
        busy        = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = LOAD;
                end
            end
            LOAD: begin
`ifdef BOOTH_DIV_DZ_BYPASS_EN
                if (r_divZero) begin
                    w_nextState = FIX;
                end else begin
                    w_nextState = ITER;
                end
`else
                w_nextState = ITER;
`endif
            end
            ITER: begin
                if (r_count == CNT_W'(WIDTH - 1)) begin
                    w_nextState = FIX;
                end
            end
            FIX: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath and result registers. The operands are captured on the accepted
    // start edge. LOAD clears the partial remainder and the step counter. ITER
    // runs the division. FIX publishes the results and raises valid for
    // exactly one cycle. Results hold until the next completion.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_dividend  <= '0;
            r_negQuot   <= 1'b0;
            r_negRem    <= 1'b0;
            r_divZero   <= 1'b0;
            r_dMag      <= '0;
            r_p         <= '0;
            r_q         <= '0;
            r_count     <= '0;
            r_valid     <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_dividend <= dividend;
                        r_negRem   <= dividend[WIDTH-1];
                        r_negQuot  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        r_divZero  <= (divisor == '0);
                        r_dMag     <= w_divisorMag;
                        r_q        <= {w_dividendMag, 1'b0};
                    end
                end
                LOAD: begin
                    r_p     <= '0;
                    r_count <= '0;
                end
                ITER: begin
                    r_p     <= w_pNext;
                    r_q     <= w_qNext;
                    r_count <= r_count + CNT_W'(1);
                end
                FIX: begin
                    r_valid <= 1'b1;
                    r_dbz   <= r_divZero;
                    if (r_divZero) begin
                        r_quotient  <= '1;
                        r_remainder <= r_dividend;
                    end else begin
                        r_quotient  <= w_qSigned;
                        r_remainder <= w_rSigned;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign valid       = r_valid;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_booth_div_nr.sv
// ---------------------------------------------------------------------------
// tb_booth_div_nr
//
// Directed, table-driven bench for booth_div_nr at WIDTH=4. Each table record
// holds the operands and the hand-computed quotient, remainder and
// divide-by-zero flag. Hand-written sequences cover reset, a start that is
// ignored while busy, back-to-back issue, and reset in the middle of an
// operation.
// ---------------------------------------------------------------------------
module tb_booth_div_nr;

    localparam int WIDTH   = 4;
    localparam int FULL_LAT = WIDTH + 2;
`ifdef BOOTH_DIV_DZ_BYPASS_EN
    localparam int DZ_LAT  = 2;
`else
    localparam int DZ_LAT  = WIDTH + 2;
`endif

    typedef struct {
        logic [3:0] dvd;
        logic [3:0] dvs;
        logic [3:0] q;
        logic [3:0] r;
        logic       dz;
    } vec_t;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       start = 1'b0;
    logic [3:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       busy;
    logic       valid;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int checks = 0;
    int errors = 0;

    vec_t vecs[15];

    booth_div_nr #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .valid      (valid),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    // Watchdog in case a wait escapes its bound.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Present operands with start high, so that they are accepted at the next
    // rising edge (edge 0). Drop start just after that edge.
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
    endtask

    // Wait for valid for at most 20 edges. Return the number of edges after
    // edge 0, or 0 if valid never came. Check that busy stays high until then.
    task automatic waitValid(input string tag, output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                lat = i;
                break;
            end
            if (!busy) begin
                checkOutput({tag, "_busyHeld"}, 32'(busy), 32'd1);
            end
        end
    endtask

    task automatic runOp(input string tag, input vec_t v);
        int lat;
        int expLat;
        applyStimulus(v.dvd, v.dvs);
        checkOutput({tag, "_busyAtEdge0"}, 32'(busy), 32'd1);
        waitValid(tag, lat);
        expLat = (v.dvs == 4'd0) ? DZ_LAT : FULL_LAT;
        checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, "_busyAtValid"}, 32'(busy), 32'd0);
        checkOutput({tag, "_quotient"}, 32'(quotient), 32'(v.q));
        checkOutput({tag, "_remainder"}, 32'(remainder), 32'(v.r));
        checkOutput({tag, "_dz"}, 32'(div_by_zero), 32'(v.dz));
        @(posedge clk);
        #1;
        checkOutput({tag, "_validPulse"}, 32'(valid), 32'd0);
        checkOutput({tag, "_quotHold"}, 32'(quotient), 32'(v.q));
    endtask

    initial begin
        int lat;
        vec_t v;

        //            dividend  divisor   quotient  remainder dz
        vecs[0]  = '{4'b0111, 4'b0010, 4'b0011, 4'b0001, 1'b0};  //  7 /  2
        vecs[1]  = '{4'b1001, 4'b0010, 4'b1101, 4'b1111, 1'b0};  // -7 /  2
        vecs[2]  = '{4'b0111, 4'b1110, 4'b1101, 4'b0001, 1'b0};  //  7 / -2
        vecs[3]  = '{4'b1000, 4'b1111, 4'b1000, 4'b0000, 1'b0};  // -8 / -1
        vecs[4]  = '{4'b1000, 4'b0011, 4'b1110, 4'b1110, 1'b0};  // -8 /  3
        vecs[5]  = '{4'b0101, 4'b0000, 4'b1111, 4'b0101, 1'b1};  //  5 /  0
        vecs[6]  = '{4'b0110, 4'b0011, 4'b0010, 4'b0000, 1'b0};  //  6 /  3
        vecs[7]  = '{4'b1000, 4'b0000, 4'b1111, 4'b1000, 1'b1};  // -8 /  0
        vecs[8]  = '{4'b0111, 4'b0111, 4'b0001, 4'b0000, 1'b0};  //  7 /  7
        vecs[9]  = '{4'b1111, 4'b0010, 4'b0000, 4'b1111, 1'b0};  // -1 /  2
        vecs[10] = '{4'b1010, 4'b1101, 4'b0010, 4'b0000, 1'b0};  // -6 / -3
        vecs[11] = '{4'b0111, 4'b1000, 4'b0000, 4'b0111, 1'b0};  //  7 / -8
        vecs[12] = '{4'b1000, 4'b1000, 4'b0001, 4'b0000, 1'b0};  // -8 / -8
        vecs[13] = '{4'b1000, 4'b0001, 4'b1000, 4'b0000, 1'b0};  // -8 /  1
        vecs[14] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b0};  //  1 /  1

        // Reset state.
        #2;
        resetn = 1'b0;
        #10;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_valid", 32'(valid), 32'd0);
        checkOutput("rst_quotient", 32'(quotient), 32'd0);
        checkOutput("rst_remainder", 32'(remainder), 32'd0);
        checkOutput("rst_dz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven vectors.
        for (int i = 0; i < 15; i++) begin
            runOp($sformatf("vec%0d", i), vecs[i]);
        end

        // A start pulse at edge 2 while busy is ignored. A start held during the
        // valid cycle is accepted on the following edge.
        applyStimulus(4'b0111, 4'b0010);
        @(posedge clk);
        @(negedge clk);
        dividend = 4'b0001;
        divisor  = 4'b0001;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        for (int i = 3; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                lat = i;
                break;
            end
        end
        checkOutput("ignore_latency", 32'(lat), 32'(FULL_LAT));
        checkOutput("ignore_quotient", 32'(quotient), 32'd3);
        checkOutput("ignore_remainder", 32'(remainder), 32'd1);
        dividend = 4'b0001;
        divisor  = 4'b0001;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("b2b_validDrop", 32'(valid), 32'd0);
        checkOutput("b2b_busyAccepted", 32'(busy), 32'd1);
        checkOutput("b2b_quotHeld", 32'(quotient), 32'd3);
        waitValid("b2b", lat);
        checkOutput("b2b_latency", 32'(lat), 32'(FULL_LAT));
        checkOutput("b2b_quotient", 32'(quotient), 32'd1);
        checkOutput("b2b_remainder", 32'(remainder), 32'd0);
        @(posedge clk);
        #1;

        // Reset between edges 3 and 4 aborts 7/2. The outputs, which still
        // hold 1/1 results, clear at once and no valid follows.
        applyStimulus(4'b0111, 4'b0010);
        repeat (3) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_valid", 32'(valid), 32'd0);
        checkOutput("abort_quotient", 32'(quotient), 32'd0);
        checkOutput("abort_remainder", 32'(remainder), 32'd0);
        checkOutput("abort_dz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("abort_noValid%0d", i), 32'(valid), 32'd0);
        end
        v = '{4'b0110, 4'b1101, 4'b1110, 4'b0000, 1'b0};  // 6 / -3
        runOp("afterAbort", v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
